// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x,y) -> atan2(y,x) and magnitude, one micro-rotation per clock.
// Optional build macro CORDIC_MAG_SCALE_EN adds a SCALE cycle that removes the CORDIC gain from mag_out.
module cordic_vectoring #(
    parameter int          ITER    = 16,
    parameter logic [17:0] K_RECIP = 18'h09B75
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic signed [17:0] x_in,
    input  logic signed [17:0] y_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [18:0] angle_out,
    output logic signed [20:0] mag_out,
    output logic               out_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
`ifdef CORDIC_MAG_SCALE_EN
    localparam logic [1:0] S_SCALE = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0]        LAST_CNT = 5'(ITER - 1);
    localparam logic signed [18:0] HALF_PI = 19'sd102944;

    logic [1:0]         r_state;
    logic [4:0]         r_count;
    logic               r_zero;
    logic signed [20:0] r_x;
    logic signed [20:0] r_y;
    logic signed [18:0] r_z;

    logic               w_accept;
    logic signed [20:0] w_x_ext;
    logic signed [20:0] w_y_ext;
    logic signed [20:0] w_x_pre;
    logic signed [20:0] w_y_pre;
    logic signed [18:0] w_z_pre;
    logic signed [20:0] w_x_sh;
    logic signed [20:0] w_y_sh;
    logic [17:0]        w_lut;
    logic signed [18:0] w_atan;
    logic signed [20:0] w_x_nxt;
    logic signed [20:0] w_y_nxt;
    logic signed [18:0] w_z_nxt;

    // atan(2^-i) in Q2.16; table shared with the rotation core, unused entries read zero
    function automatic logic [17:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 18'd51472;
            5'd1:    atan_lut = 18'd30385;
            5'd2:    atan_lut = 18'd16055;
            5'd3:    atan_lut = 18'd8150;
            5'd4:    atan_lut = 18'd4091;
            5'd5:    atan_lut = 18'd2047;
            5'd6:    atan_lut = 18'd1024;
            5'd7:    atan_lut = 18'd512;
            5'd8:    atan_lut = 18'd256;
            5'd9:    atan_lut = 18'd128;
            5'd10:   atan_lut = 18'd64;
            5'd11:   atan_lut = 18'd32;
            5'd12:   atan_lut = 18'd16;
            5'd13:   atan_lut = 18'd8;
            5'd14:   atan_lut = 18'd4;
            5'd15:   atan_lut = 18'd2;
            default: atan_lut = 18'd0;
        endcase
    endfunction

`ifdef CORDIC_MAG_SCALE_EN
    // Truncating gain correction: (x * K_RECIP) >>> 16, K_RECIP treated as unsigned Q0.16
    function automatic logic signed [20:0] scale_mag(input logic signed [20:0] x);
        logic signed [39:0] prod;
        prod      = x * $signed({1'b0, K_RECIP});
        scale_mag = prod[36:16];
    endfunction
`else
    logic w_unused_k;
    assign w_unused_k = ^K_RECIP;
`endif

    assign in_ready = (r_state == S_IDLE) && reset_n;
    assign w_accept = in_valid && in_ready;
    assign w_x_ext  = {{3{x_in[17]}}, x_in};
    assign w_y_ext  = {{3{y_in[17]}}, y_in};

    // Left half-plane vectors are pre-rotated by +/-pi/2 so the iterations only cover (-pi/2, pi/2]
    always_comb begin
        w_x_pre = w_x_ext;
        w_y_pre = w_y_ext;
        w_z_pre = '0;
        if (x_in[17]) begin
            if (!y_in[17]) begin
                w_x_pre = w_y_ext;
                w_y_pre = -w_x_ext;
                w_z_pre = HALF_PI;
            end else begin
                w_x_pre = -w_y_ext;
                w_y_pre = w_x_ext;
                w_z_pre = -HALF_PI;
            end
        end
    end

    assign w_x_sh = r_x >>> r_count;
    assign w_y_sh = r_y >>> r_count;
    assign w_lut  = atan_lut(r_count);
    assign w_atan = {w_lut[17], w_lut};

    always_comb begin
        if (!r_y[20]) begin
            w_x_nxt = r_x + w_y_sh;
            w_y_nxt = r_y - w_x_sh;
            w_z_nxt = r_z + w_atan;
        end else begin
            w_x_nxt = r_x - w_y_sh;
            w_y_nxt = r_y + w_x_sh;
            w_z_nxt = r_z - w_atan;
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_x <= w_x_pre;
            r_y <= w_y_pre;
            r_z <= w_z_pre;
        end else if (r_state == S_ITER) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            r_z <= w_z_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_zero    <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_ITER;
                        r_count <= '0;
                        r_zero  <= (x_in == '0) && (y_in == '0);
                    end
                end
                S_ITER: begin
                    r_count <= r_count + 5'd1;
                    if (r_count == LAST_CNT) begin
`ifdef CORDIC_MAG_SCALE_EN
                        r_state <= S_SCALE;
`else
                        r_state   <= S_DONE;
                        angle_out <= r_zero ? '0 : w_z_nxt;
                        mag_out   <= r_zero ? '0 : w_x_nxt;
                        out_valid <= 1'b1;
`endif
                    end
                end
`ifdef CORDIC_MAG_SCALE_EN
                S_SCALE: begin
                    r_state   <= S_DONE;
                    angle_out <= r_zero ? '0 : r_z;
                    mag_out   <= r_zero ? '0 : scale_mag(r_x);
                    out_valid <= 1'b1;
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
